// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - MAX_WIDTH : widest operand the datapath is meant to be built with
//   - idx_w()   : width of the bit index counter for a given operand width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Never returns 0, so the index counter always has at least one bit.
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_sub_pkg

// File: rtl/fullsub_bit.sv
// -----------------------------------------------------------------------------
// fullsub_bit
//   One-bit full subtractor built from gate primitives. It mirrors the
//   structure of the gate-level adder cell, so every internal net is a named
//   wire that can be probed directly.
//   Ports:
//     a    : minuend bit
//     b    : subtrahend bit
//     bin  : borrow in
//     d    : difference bit      d    = a ^ b ^ bin
//     bout : borrow out          bout = (~a & b) | (~(a ^ b) & bin)
// -----------------------------------------------------------------------------
module fullsub_bit (
    input  logic      a,
    input  logic      b,
    input  logic      bin,
    output wire logic d,
    output wire logic bout
);

    wire a_xor_b;     // a ^ b
    wire a_n;         // ~a
    wire a_xnor_b;    // ~(a ^ b)
    wire borrow_gen;  // ~a & b     : this bit creates a borrow on its own
    wire borrow_prop; // ~(a^b)&bin : equal bits pass the incoming borrow on

    xor u_x1 (a_xor_b,     a,        b);
    xor u_x2 (d,           a_xor_b,  bin);
    not u_n1 (a_n,         a);
    not u_n2 (a_xnor_b,    a_xor_b);
    and u_a1 (borrow_gen,  a_n,      b);
    and u_a2 (borrow_prop, a_xnor_b, bin);
    or  u_o1 (bout,        borrow_gen, borrow_prop);

endmodule : fullsub_bit

// File: rtl/serial_subber.sv
// -----------------------------------------------------------------------------
// serial_subber
//   Bit-serial subtractor: accepts an operand pair on a valid/ready request
//   channel, computes a - b LSB-first one bit per clock through a single
//   fullsub_bit cell, and presents the parallel difference and final borrow
//   on a valid/ready result channel.
//   Parameters:
//     WIDTH     : operand/result width, legal range 2..MAX_WIDTH
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     in_valid   : operand pair valid        in_ready  : can accept a pair
//     a, b       : minuend / subtrahend
//     out_valid  : result valid              out_ready : consumer takes result
//     diff       : a - b modulo 2^WIDTH      borrow    : 1 when a < b
//     busy       : high while computing      bit_idx   : bit handled this cycle
// -----------------------------------------------------------------------------
module serial_subber
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic [IDX_W-1:0] bit_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [WIDTH-1:0] res_next;
    logic             bin_q;
    logic             d_bit, bout_bit;
    logic             accept, last_bit;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [IDX_W-1:0] idx_q;

    fullsub_bit u_fullsub (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (idx_q == LAST_IDX);
    // The new difference bit enters at the MSB; after WIDTH shifts the LSB
    // computed first has arrived at bit 0.
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bin_q    <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                res_sr <= '0;
                bin_q  <= 1'b0;
                idx_q  <= '0;
            end else if (state_q == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= res_next;
                bin_q  <= bout_bit;
                if (last_bit) begin
                    // Publish the result; diff/borrow then hold until the
                    // next operation completes.
                    diff_q   <= res_next;
                    borrow_q <= bout_bit;
                    idx_q    <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign diff    = diff_q;
    assign borrow  = borrow_q;
    assign bit_idx = idx_q;

endmodule : serial_subber

// File: tb/tb_serial_subber.sv
// -----------------------------------------------------------------------------
// tb_serial_subber
//   Directed bench for serial_subber with two instances: WIDTH=8 and WIDTH=2.
//   Inputs are driven on the falling edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_serial_subber;

    logic clk;
    logic rst_n;

    // WIDTH = 8 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8, busy8;
    logic [7:0] a8, b8, diff8;
    logic [2:0] bit_idx8;

    // WIDTH = 2 instance
    logic       in_valid2, in_ready2, out_valid2, out_ready2, borrow2, busy2;
    logic [1:0] a2, b2, diff2;
    logic [0:0] bit_idx2;

    int tests = 0;
    int fails = 0;

    serial_subber #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8),
        .busy      (busy8),
        .bit_idx   (bit_idx8)
    );

    serial_subber #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .diff      (diff2),
        .borrow    (borrow2),
        .busy      (busy2),
        .bit_idx   (bit_idx2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for out_valid on the 8-bit instance; counts edges waited
    // and how many of the sampled cycles had busy high.
    task automatic wait_ov8(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!out_valid8 && cyc < 100) begin
            busy_cnt += int'(busy8);
            @(negedge clk);
            cyc++;
        end
    endtask

    // One full operation on the 8-bit instance with out_ready held high.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] exp_d, input logic exp_b);
        int cyc, bc;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready8, 1);
        a8 = av; b8 = bv; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        check({tag, "_busy_start"}, busy8, 1);
        wait_ov8(cyc, bc);
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_busy_cycles"}, bc, 8);
        check({tag, "_diff"}, diff8, exp_d);
        check({tag, "_borrow"}, borrow8, exp_b);
        @(negedge clk);
        check({tag, "_ov_drop"}, out_valid8, 0);
        check({tag, "_diff_hold"}, diff8, exp_d);
    endtask

    // One full operation on the 2-bit instance, expectations from a model.
    task automatic op2(input logic [1:0] av, input logic [1:0] bv);
        int cyc;
        logic [2:0] full;
        full = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        a2 = av; b2 = bv; in_valid2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("w2_%0d_%0d_latency", av, bv), cyc, 2);
        check($sformatf("w2_%0d_%0d_diff", av, bv), diff2, full[1:0]);
        check($sformatf("w2_%0d_%0d_borrow", av, bv), borrow2, full[2]);
        @(negedge clk);
    endtask

    initial begin : stimulus
        int cyc, bc, ov_cnt, nacc, nres;
        bit seen;
        logic [15:0] pending[$];
        logic [15:0] pair;
        logic [8:0]  full8;

        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_busy", busy8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", borrow8, 0);
        check("rst_bit_idx", bit_idx8, 0);
        rst_n = 1'b1;

        // Basic operation: 0x5A - 0x3C = 0x1E
        op8("basic", 8'h5A, 8'h3C, 8'h1E, 1'b0);

        // Underflow, then back-to-back with in_valid held to measure issue interval
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80;
        cyc = 1;
        seen = 1'b0;
        while (!in_ready8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid8 && !seen) begin
                seen = 1'b1;
                check("under_diff", diff8, 8'hFF);
                check("under_borrow", borrow8, 1);
            end
        end
        check("under_seen", seen, 1);
        check("issue_interval", cyc, 10);
        @(negedge clk);
        in_valid8 = 1'b0;
        wait_ov8(cyc, bc);
        check("equal_latency", cyc, 8);
        check("equal_diff", diff8, 8'h00);
        check("equal_borrow", borrow8, 0);
        @(negedge clk);

        // Backpressure: 0x10 - 0x03 = 0x0D held for 5 cycles
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h03; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b1;  // kept high: must be ignored outside IDLE
        a8 = 8'hAA; b8 = 8'h55;
        wait_ov8(cyc, bc);
        check("bp_latency", cyc, 8);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_ov_%0d", i), out_valid8, 1);
            check($sformatf("bp_diff_%0d", i), diff8, 8'h0D);
            check($sformatf("bp_in_ready_%0d", i), in_ready8, 0);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        check("bp_borrow", borrow8, 0);
        @(negedge clk);
        check("bp_ov_drop", out_valid8, 0);
        check("bp_back_idle", in_ready8, 1);

        // Reset in the middle of RUN
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_bit_idx", bit_idx8, 4);
        check("mid_busy", busy8, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_in_ready", in_ready8, 1);
        check("arst_out_valid", out_valid8, 0);
        check("arst_diff", diff8, 0);
        check("arst_borrow", borrow8, 0);
        check("arst_bit_idx", bit_idx8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ov_cnt += int'(out_valid8);
        end
        check("arst_no_result", ov_cnt, 0);
        op8("post_rst", 8'h07, 8'h09, 8'hFE, 1'b1);

        // Continuous in_valid with operands changing every cycle
        nacc = 0;
        nres = 0;
        cyc = 0;
        out_ready8 = 1'b1;
        while (nres < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (out_valid8) begin
                if (pending.size() > 0) begin
                    pair = pending.pop_front();
                    full8 = {1'b0, pair[15:8]} - {1'b0, pair[7:0]};
                    check($sformatf("rnd_%0d_diff", nres), diff8, full8[7:0]);
                    check($sformatf("rnd_%0d_borrow", nres), borrow8, full8[8]);
                end else begin
                    check("rnd_spurious", 1, 0);
                end
                nres++;
            end
            in_valid8 = (nacc < 100);
            if (in_ready8 && in_valid8) begin
                case (nacc)
                    0:       begin a8 = 8'h00; b8 = 8'hFF; end
                    1:       begin a8 = 8'hFF; b8 = 8'h00; end
                    2:       begin a8 = 8'hFF; b8 = 8'hFF; end
                    3:       begin a8 = 8'h00; b8 = 8'h00; end
                    default: begin a8 = 8'($urandom); b8 = 8'($urandom); end
                endcase
                pending.push_back({a8, b8});
                nacc++;
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        in_valid8 = 1'b0;
        check("rnd_count", nres, 100);

        // WIDTH = 2 exhaustive
        check("w2_reset_idle", in_ready2, 1);
        for (int i = 0; i < 16; i++) begin
            op2(2'(i >> 2), 2'(i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_subber
